pcie_rx: RTL and testbench
==========================

Name: pcie_rx

Overview:
- Receive-side TLP parser. Consumes the 64-bit AXI stream from the PCI Express core and decodes three kinds of TLP.
- Host register writes (MWr) drive a register write strobe.
- Host register reads (MRd) drive a read strobe plus requester ID/tag, which feed the read completion inputs of pcie_tx.
- DMA read completions (CplD) answering pcie_tx's 512-byte read requests are realigned into qwords with a tag and an index.
- All other TLPs are discarded.

Parameters:
ADDR_BITS, 10, width of qword register address taken from TLP address bits [ADDR_BITS+2:3]

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
axis_rx_tdata  in  64  beat; dword0 in [31:0], dword1 in [63:32]
axis_rx_tvalid  in  1  beat valid
axis_rx_tlast  in  1  last beat of TLP
axis_rx_tready  out  1  always 1 out of reset; 0 while reset asserted
reg_wvalid  out  1  one-cycle register write strobe
reg_waddr  out  ADDR_BITS  qword address of write
reg_wdata  out  64  write data, byte-swapped per dword to little-endian
reg_rvalid  out  1  one-cycle register read strobe
reg_raddr  out  ADDR_BITS  qword address of read
read_completion_rid_tag  out  24  {requester ID, tag} of last MRd; held
read_completion_lower_addr  out  4  address bits [6:3] of last MRd; held
cpl_valid  out  1  one completion qword valid
cpl_data  out  64  completion qword, byte-swapped per dword
cpl_tag  out  8  tag from CplD dword2[15:8]
cpl_index  out  6  qword index within the 512-byte request
cpl_last  out  1  last qword of this CplD TLP

Behaviour:
- All outputs reset to 0; reset is asynchronous to every register. Reset mid-TLP aborts it: the first beat after reset is treated as a header.
- Accept a beat when axis_rx_tvalid is high; there is no backpressure.
- Decode dword0[31:24]: 0x00 = MRd3, 0x40 = MWr3, 0x4A = CplD. Length is dword0[9:0]. EP is dword0[14].
- Drop conditions:
  - EP set.
  - 4DW headers (0x20, 0x60).
  - MRd/MWr with length != 2.
  - Any other type.
- States:
  - IDLE: header beat 0. Go to HDR1 if supported, else DROP. A header beat that is also tlast returns to IDLE.
  - HDR1: beat 1 = {data dw0 or CplD data dw0, address or dword2}.
    - MRd: pulse reg_rvalid 1 cycle later. Load reg_raddr, rid_tag = dword1[31:8], lower_addr = addr[6:3]. Return to IDLE.
    - MWr: hold upper dword. Go to WDATA.
    - CplD: hold upper dword and remaining length. Compute start index = (512 − byte count dword1[11:0])[8:3]. Go to CDATA.
  - WDATA: reg_wvalid one cycle after this beat. reg_wdata = {swap(beat[31:0]), swap(held)}. Go to IDLE.
  - CDATA: each beat emits qword {swap(beat[31:0]), swap(held)} one cycle later, then holds beat[63:32]. Decrement remaining by 2 per qword. Increment cpl_index (wraps at 64).
    - cpl_last is set on the qword that brings remaining to 0.
    - An odd final dword is discarded.
    - Go to IDLE on tlast.
  - DROP: consume beats until tlast, then IDLE.
- tlast seen before the expected beat count: return to IDLE, emitting nothing further.
- A new MRd overwrites rid_tag/lower_addr. Only one outstanding register read is supported.
- Latency: every strobe asserts exactly 1 cycle after the completing beat.

Optional Feature:
- PCIE_RX_DROP_COUNT_EN defined: adds output drop_count[15:0], reset 0. It increments once per TLP entering DROP and saturates at 0xFFFF.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- MWr3 beats {0x0000000F_40000002, 0x44332211_00000018}, {x, 0x88776655} -> one cycle after beat 2: reg_wvalid = 1, reg_waddr = 3, reg_wdata = 0x55667788_11223344.
- MRd3 {0x1234AB0F_00000002}, {x, 0x00000048} -> reg_rvalid pulse, reg_raddr = 9, rid_tag = 0x1234AB, lower_addr = 9.
- CplD with length 16, byte count 512, tag 0x05 over 9 beats -> 8 cpl_valid cycles, cpl_index 0..7, cpl_tag = 5, cpl_last only on the 8th.
- Second CplD with byte count 448 -> first cpl_index = 8.
- MWr4 (0x60), then MRd with length 1, then EP-set CplD -> no strobes. With PCIE_RX_DROP_COUNT_EN, drop_count = 3.
- Assert reset during a CplD, release it, then send an MRd -> no cpl_valid after reset and the MRd decodes correctly. axis_rx_tready is 0 during reset.

Source files
------------

// File: rtl/pcie_rx.sv
// Receive-side TLP parser: decodes MRd3/MWr3 register accesses and realigns CplD payload into qwords.
// Optional macro PCIE_RX_DROP_COUNT_EN adds a saturating drop_count output.
module pcie_rx #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [63:0]          axis_rx_tdata,
  input  logic                 axis_rx_tvalid,
  input  logic                 axis_rx_tlast,
  output logic                 axis_rx_tready,
  output logic                 reg_wvalid,
  output logic [ADDR_BITS-1:0] reg_waddr,
  output logic [63:0]          reg_wdata,
  output logic                 reg_rvalid,
  output logic [ADDR_BITS-1:0] reg_raddr,
  output logic [23:0]          read_completion_rid_tag,
  output logic [3:0]           read_completion_lower_addr,
  output logic                 cpl_valid,
  output logic [63:0]          cpl_data,
  output logic [7:0]           cpl_tag,
  output logic [5:0]           cpl_index,
  output logic                 cpl_last
`ifdef PCIE_RX_DROP_COUNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_WDATA, S_CDATA, S_DROP} state_t;
  typedef enum logic [1:0] {K_NONE, K_MRD, K_MWR, K_CPL} kind_t;

  localparam logic [7:0] FMT_MRD3 = 8'h00;
  localparam logic [7:0] FMT_MWR3 = 8'h40;
  localparam logic [7:0] FMT_CPLD = 8'h4A;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                 state_q, state_d;
  kind_t                  rx_kind;
  kind_t                  kind_p1;
  logic [31:0]            hdr_dw1_p1;
  logic [9:0]             len_p1;
  logic [31:0]            held_dw_p1;
  logic [ADDR_BITS-1:0]   waddr_p1;
  logic [10:0]            rem_p1;
  logic [5:0]             idx_p1;
  logic [7:0]             tag_p1;
  logic [11:0]            bc_offset;

  // Bus never stalls; ready only drops while reset is held.
  assign axis_rx_tready = ~reset;
  assign bc_offset      = 12'd512 - hdr_dw1_p1[11:0];

  always_comb begin
    rx_kind = K_NONE;
    case (axis_rx_tdata[31:24])
      FMT_MRD3: if (axis_rx_tdata[9:0] == 10'd2) rx_kind = K_MRD;
      FMT_MWR3: if (axis_rx_tdata[9:0] == 10'd2) rx_kind = K_MWR;
      FMT_CPLD: rx_kind = K_CPL;
      default:  rx_kind = K_NONE;
    endcase
    if (axis_rx_tdata[14]) rx_kind = K_NONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (axis_rx_tvalid) begin
      case (state_q)
        S_IDLE: begin
          if (axis_rx_tlast)          state_d = S_IDLE;
          else if (rx_kind != K_NONE) state_d = S_HDR1;
          else                        state_d = S_DROP;
        end
        S_HDR1: begin
          if (kind_p1 == K_MRD || axis_rx_tlast) state_d = S_IDLE;
          else if (kind_p1 == K_MWR)             state_d = S_WDATA;
          else                                   state_d = S_CDATA;
        end
        S_WDATA: state_d = S_IDLE;
        S_CDATA: if (axis_rx_tlast) state_d = S_IDLE;
        S_DROP:  if (axis_rx_tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stage p1: header capture and per-beat output registers (strobes one cycle after the beat)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kind_p1                    <= K_NONE;
      hdr_dw1_p1                 <= '0;
      len_p1                     <= '0;
      held_dw_p1                 <= '0;
      waddr_p1                   <= '0;
      rem_p1                     <= '0;
      idx_p1                     <= '0;
      tag_p1                     <= '0;
      reg_wvalid                 <= 1'b0;
      reg_waddr                  <= '0;
      reg_wdata                  <= '0;
      reg_rvalid                 <= 1'b0;
      reg_raddr                  <= '0;
      read_completion_rid_tag    <= '0;
      read_completion_lower_addr <= '0;
      cpl_valid                  <= 1'b0;
      cpl_data                   <= '0;
      cpl_tag                    <= '0;
      cpl_index                  <= '0;
      cpl_last                   <= 1'b0;
    end else begin
      reg_wvalid <= 1'b0;
      reg_rvalid <= 1'b0;
      cpl_valid  <= 1'b0;
      cpl_last   <= 1'b0;
      if (axis_rx_tvalid) begin
        case (state_q)
          S_IDLE: begin
            kind_p1    <= rx_kind;
            hdr_dw1_p1 <= axis_rx_tdata[63:32];
            len_p1     <= axis_rx_tdata[9:0];
          end
          S_HDR1: begin
            held_dw_p1 <= axis_rx_tdata[63:32];
            case (kind_p1)
              K_MRD: begin
                reg_rvalid                 <= 1'b1;
                reg_raddr                  <= axis_rx_tdata[ADDR_BITS+2:3];
                read_completion_rid_tag    <= hdr_dw1_p1[31:8];
                read_completion_lower_addr <= axis_rx_tdata[6:3];
              end
              K_MWR: waddr_p1 <= axis_rx_tdata[ADDR_BITS+2:3];
              K_CPL: begin
                // A zero length field encodes 1024 dwords.
                rem_p1 <= {(len_p1 == 10'd0), len_p1};
                idx_p1 <= bc_offset[8:3];
                tag_p1 <= axis_rx_tdata[15:8];
              end
              default: ;
            endcase
          end
          S_WDATA: begin
            reg_wvalid <= 1'b1;
            reg_waddr  <= waddr_p1;
            reg_wdata  <= {swap32(axis_rx_tdata[31:0]), swap32(held_dw_p1)};
          end
          S_CDATA: begin
            held_dw_p1 <= axis_rx_tdata[63:32];
            // Fewer than two dwords left means only padding or an odd tail dword.
            if (rem_p1 >= 11'd2) begin
              cpl_valid <= 1'b1;
              cpl_data  <= {swap32(axis_rx_tdata[31:0]), swap32(held_dw_p1)};
              cpl_tag   <= tag_p1;
              cpl_index <= idx_p1;
              cpl_last  <= (rem_p1 == 11'd2);
              rem_p1    <= rem_p1 - 11'd2;
              idx_p1    <= idx_p1 + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PCIE_RX_DROP_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_count <= '0;
    else if (axis_rx_tvalid && state_q == S_IDLE && state_d == S_DROP)
      drop_count <= sat_inc16(drop_count);
  end
`endif

endmodule

// File: tb/tb_pcie_rx.sv
// Directed bench for pcie_rx: register write/read decode, CplD realignment, drops and mid-TLP reset.
module tb_pcie_rx;

  logic        clock;
  logic        reset;
  logic [63:0] axis_rx_tdata;
  logic        axis_rx_tvalid;
  logic        axis_rx_tlast;
  logic        axis_rx_tready;
  logic        reg_wvalid;
  logic [9:0]  reg_waddr;
  logic [63:0] reg_wdata;
  logic        reg_rvalid;
  logic [9:0]  reg_raddr;
  logic [23:0] read_completion_rid_tag;
  logic [3:0]  read_completion_lower_addr;
  logic        cpl_valid;
  logic [63:0] cpl_data;
  logic [7:0]  cpl_tag;
  logic [5:0]  cpl_index;
  logic        cpl_last;
`ifdef PCIE_RX_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pcie_rx #(.ADDR_BITS(10)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .axis_rx_tdata              (axis_rx_tdata),
    .axis_rx_tvalid             (axis_rx_tvalid),
    .axis_rx_tlast              (axis_rx_tlast),
    .axis_rx_tready             (axis_rx_tready),
    .reg_wvalid                 (reg_wvalid),
    .reg_waddr                  (reg_waddr),
    .reg_wdata                  (reg_wdata),
    .reg_rvalid                 (reg_rvalid),
    .reg_raddr                  (reg_raddr),
    .read_completion_rid_tag    (read_completion_rid_tag),
    .read_completion_lower_addr (read_completion_lower_addr),
    .cpl_valid                  (cpl_valid),
    .cpl_data                   (cpl_data),
    .cpl_tag                    (cpl_tag),
    .cpl_index                  (cpl_index),
    .cpl_last                   (cpl_last)
`ifdef PCIE_RX_DROP_COUNT_EN
    ,
    .drop_count                 (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one beat; returns 1ns after the edge that accepts it.
  task automatic beat(input logic [63:0] d, input logic last);
    axis_rx_tdata  = d;
    axis_rx_tvalid = 1'b1;
    axis_rx_tlast  = last;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    axis_rx_tvalid = 1'b0;
    axis_rx_tlast  = 1'b0;
    axis_rx_tdata  = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 64'({reg_wvalid, reg_rvalid, cpl_valid}), 64'd0);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {<<8{x}};
  endfunction

  function automatic logic [31:0] dw(input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return {kk, 8'hA5, kk + 8'h10, 8'h3C};
  endfunction

  initial begin
    reset          = 1'b1;
    axis_rx_tdata  = '0;
    axis_rx_tvalid = 1'b0;
    axis_rx_tlast  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tready", 64'(axis_rx_tready), 64'd0);
    check("rst_strobes", 64'({reg_wvalid, reg_rvalid, cpl_valid, cpl_last}), 64'd0);
    check("rst_rid_tag", 64'(read_completion_rid_tag), 64'd0);
    check("rst_wdata", reg_wdata, 64'd0);
    reset = 1'b0;
    #1;
    check("tready_up", 64'(axis_rx_tready), 64'd1);
    idle_cycle();

    // MWr3, address 0x18 -> qword 3
    beat(64'h0000000F_40000002, 1'b0);
    check_quiet("mwr_b0");
    beat(64'h44332211_00000018, 1'b0);
    check_quiet("mwr_b1");
    beat(64'h00000000_88776655, 1'b1);
    check("mwr_wvalid", 64'(reg_wvalid), 64'd1);
    check("mwr_waddr", 64'(reg_waddr), 64'd3);
    check("mwr_wdata", reg_wdata, 64'h55667788_11223344);
    idle_cycle();
    check("mwr_wvalid_pulse", 64'(reg_wvalid), 64'd0);

    // MRd3, address 0x48 -> qword 9
    beat(64'h1234AB0F_00000002, 1'b0);
    check_quiet("mrd_b0");
    beat(64'h00000000_00000048, 1'b1);
    check("mrd_rvalid", 64'(reg_rvalid), 64'd1);
    check("mrd_raddr", 64'(reg_raddr), 64'd9);
    check("mrd_rid_tag", 64'(read_completion_rid_tag), 64'h1234AB);
    check("mrd_lower", 64'(read_completion_lower_addr), 64'd9);
    idle_cycle();
    check("mrd_rvalid_pulse", 64'(reg_rvalid), 64'd0);
    check("mrd_rid_held", 64'(read_completion_rid_tag), 64'h1234AB);

    // CplD length 16, byte count 512, tag 5
    beat(64'h01000200_4A000010, 1'b0);
    check_quiet("cpl_b0");
    beat({dw(0), 32'h0000_0500}, 1'b0);
    check_quiet("cpl_b1");
    for (int n = 2; n <= 9; n++) begin
      beat({dw(2*n-2), dw(2*n-3)}, n == 9);
      check($sformatf("cpl_valid_%0d", n-2), 64'(cpl_valid), 64'd1);
      check($sformatf("cpl_data_%0d", n-2), cpl_data, {bswap(dw(2*n-3)), bswap(dw(2*n-4))});
      check($sformatf("cpl_index_%0d", n-2), 64'(cpl_index), 64'(n-2));
      check($sformatf("cpl_tag_%0d", n-2), 64'(cpl_tag), 64'd5);
      check($sformatf("cpl_last_%0d", n-2), 64'(cpl_last), 64'(n == 9));
    end
    idle_cycle();
    check("cpl_done", 64'(cpl_valid), 64'd0);

    // CplD byte count 448 -> start index 8, single qword, tag 7
    beat(64'h010001C0_4A000002, 1'b0);
    beat({dw(20), 32'h0000_0700}, 1'b0);
    check_quiet("cpl2_b1");
    beat({32'hDEADBEEF, dw(21)}, 1'b1);
    check("cpl2_valid", 64'(cpl_valid), 64'd1);
    check("cpl2_index", 64'(cpl_index), 64'd8);
    check("cpl2_tag", 64'(cpl_tag), 64'd7);
    check("cpl2_last", 64'(cpl_last), 64'd1);
    check("cpl2_data", cpl_data, {bswap(dw(21)), bswap(dw(20))});
    idle_cycle();

    // Dropped: MWr4, MRd length 1, EP-set CplD
    beat(64'h0000000F_60000002, 1'b0);
    check_quiet("mwr4_b0");
    beat(64'h00000018_00000000, 1'b0);
    check_quiet("mwr4_b1");
    beat(64'h88776655_44332211, 1'b1);
    check_quiet("mwr4_b2");
    beat(64'h1234AB0F_00000001, 1'b0);
    check_quiet("mrd1_b0");
    beat(64'h00000000_00000048, 1'b1);
    check_quiet("mrd1_b1");
    beat(64'h01000200_4A004002, 1'b0);
    check_quiet("ep_b0");
    beat({dw(0), 32'h0000_0500}, 1'b0);
    check_quiet("ep_b1");
    beat({32'h0, dw(1)}, 1'b1);
    check_quiet("ep_b2");
    idle_cycle();
`ifdef PCIE_RX_DROP_COUNT_EN
    check("drop_count", 64'(drop_count), 64'd3);
`endif
    check("rid_after_drops", 64'(read_completion_rid_tag), 64'h1234AB);

    // Reset in the middle of a CplD, then an MRd
    beat(64'h01000200_4A000010, 1'b0);
    beat({dw(0), 32'h0000_0500}, 1'b0);
    beat({dw(2), dw(1)}, 1'b0);
    check("rcpl_valid", 64'(cpl_valid), 64'd1);
    axis_rx_tvalid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_tready", 64'(axis_rx_tready), 64'd0);
    check("mid_rst_cpl", 64'(cpl_valid), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_tready", 64'(axis_rx_tready), 64'd1);
    beat(64'hBEEF120F_00000002, 1'b0);
    check_quiet("rmrd_b0");
    beat(64'h00000000_00000038, 1'b1);
    check("rmrd_cpl", 64'(cpl_valid), 64'd0);
    check("rmrd_rvalid", 64'(reg_rvalid), 64'd1);
    check("rmrd_raddr", 64'(reg_raddr), 64'd7);
    check("rmrd_rid_tag", 64'(read_completion_rid_tag), 64'hBEEF12);
    check("rmrd_lower", 64'(read_completion_lower_addr), 64'd7);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
